// File: rtl/ring_lock_ctrl.sv
// Sweep-and-lock controller: one shared sweep engine steps each ring's tuning
// across full scale, parks it at the peak drop-port current and verifies lock.
module ring_lock_ctrl #(
  parameter int  NumRings        = 4,
  parameter int  SweepSteps      = 11,
  parameter real TuningFullScale = 10.0,
  parameter int  SettleCycles    = 2,
  parameter real LockRatio       = 0.9,
  parameter real MinPeak         = 1.0e-3,
  localparam int IdxW = (NumRings > 1) ? $clog2(NumRings) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  real                 i_real_pd_current [NumRings],
  output real                 o_real_tuning_dist [NumRings],
  output logic [NumRings-1:0] o_locked,
  output logic                o_busy,
  output logic                o_done,
  output logic [IdxW-1:0]     o_ring_idx
);

  localparam int StepW = $clog2(SweepSteps);
  localparam int CntW  = (SettleCycles > 0) ? $clog2(SettleCycles + 1) : 1;
  localparam logic [StepW-1:0] LastStep   = StepW'(SweepSteps - 1);
  localparam logic [CntW-1:0]  SettleLast = CntW'(SettleCycles);
  localparam logic [IdxW-1:0]  LastRing   = IdxW'(NumRings - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_VERIFY,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [IdxW-1:0]      ring_reg, ring_next;
  logic [StepW-1:0]     step_reg, step_next;
  logic [StepW-1:0]     argmax_reg, argmax_next;
  logic [CntW-1:0]      settle_reg, settle_next;
  logic [NumRings-1:0]  locked_reg, locked_next;
  real                  peak_reg, peak_next;
  real                  tuning_reg [NumRings];
  real                  tuning_next [NumRings];

  logic sample_cycle;
  logic new_peak;
  real  cur;

  function automatic real step_to_tuning(input logic [StepW-1:0] s);
    return (real'(s) * TuningFullScale) / real'(SweepSteps - 1);
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      ring_reg   <= '0;
      step_reg   <= '0;
      argmax_reg <= '0;
      settle_reg <= '0;
      locked_reg <= '0;
      peak_reg   <= 0.0;
      for (int i = 0; i < NumRings; i++) tuning_reg[i] <= 0.0;
    end else begin
      state_reg  <= state_next;
      ring_reg   <= ring_next;
      step_reg   <= step_next;
      argmax_reg <= argmax_next;
      settle_reg <= settle_next;
      locked_reg <= locked_next;
      peak_reg   <= peak_next;
      for (int i = 0; i < NumRings; i++) tuning_reg[i] <= tuning_next[i];
    end
  end

  always_comb begin
    state_next   = state_reg;
    ring_next    = ring_reg;
    step_next    = step_reg;
    argmax_next  = argmax_reg;
    settle_next  = settle_reg;
    locked_next  = locked_reg;
    peak_next    = peak_reg;
    tuning_next  = tuning_reg;
    sample_cycle = (settle_reg == SettleLast);
    cur          = i_real_pd_current[ring_reg];
    // Step 0 always wins: equivalent to starting each sweep from a -inf peak.
    new_peak     = (step_reg == '0) || (cur > peak_reg);

    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next     = ST_SWEEP;
          ring_next      = '0;
          step_next      = '0;
          settle_next    = '0;
          argmax_next    = '0;
          peak_next      = 0.0;
          locked_next    = '0;
          tuning_next[0] = 0.0;
        end
      end
      ST_SWEEP: begin
        if (!sample_cycle) begin
          settle_next = settle_reg + CntW'(1);
        end else begin
          settle_next = '0;
          if (new_peak) begin
            peak_next   = cur;
            argmax_next = step_reg;
          end
          if (step_reg != LastStep) begin
            step_next             = step_reg + StepW'(1);
            tuning_next[ring_reg] = step_to_tuning(step_reg + StepW'(1));
          end else begin
            state_next            = ST_VERIFY;
            tuning_next[ring_reg] = step_to_tuning(argmax_next);
          end
        end
      end
      ST_VERIFY: begin
        if (!sample_cycle) begin
          settle_next = settle_reg + CntW'(1);
        end else begin
          settle_next           = '0;
          locked_next[ring_reg] = (peak_reg >= MinPeak) && (cur >= LockRatio * peak_reg);
          state_next            = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (ring_reg != LastRing) begin
          ring_next              = ring_reg + IdxW'(1);
          step_next              = '0;
          settle_next            = '0;
          argmax_next            = '0;
          peak_next              = 0.0;
          tuning_next[ring_next] = 0.0;
          state_next             = ST_SWEEP;
        end else begin
          ring_next  = '0;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NumRings; gi++) begin : g_tuning_out
      assign o_real_tuning_dist[gi] = tuning_reg[gi];
    end
  endgenerate

  assign o_locked   = locked_reg;
  assign o_busy     = (state_reg != ST_IDLE);
  assign o_done     = (state_reg == ST_DONE);
  assign o_ring_idx = ring_reg;

endmodule

// File: doc/ring_lock_ctrl.md
Name: ring_lock_ctrl

Overview:
Sequential sweep-and-lock controller for a bank of NumRings microrings sharing one time-multiplexed sweep engine. On start, each ring's tuning distance is swept in turn across 0..TuningFullScale. The controller records the drop-port photodetector current at each step, parks the ring at the step with peak current, and then verifies lock. It sits between the drop-port photodetector outputs and each microring's tuning input, generalising the single-ring, untuned open-loop transfer-function setup into a closed-loop, multi-channel one.

Parameters:
NumRings, 4, number of rings/channels controlled; must be >= 1.
SweepSteps, 11, tuning points per sweep; must be >= 2; step s maps to tuning s*TuningFullScale/(SweepSteps-1).
TuningFullScale, 10.0 (real), maximum tuning distance driven.
SettleCycles, 2, wait cycles after each tuning update before sampling; 0 is legal.
LockRatio, 0.9 (real), verify sample must be >= LockRatio*peak to declare lock.
MinPeak, 1.0e-3 (real), peak below this means no resonance found.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  asynchronous active-low reset.
i_start  input  1  single-cycle start request, sampled only in IDLE.
i_real_pd_current  input  real[NumRings]  drop-port photodetector current per ring.
o_real_tuning_dist  output  real[NumRings]  tuning distance driven to each ring.
o_locked  output  [NumRings-1:0]  per-ring lock result from the most recent run.
o_busy  output  1  high in every state except IDLE.
o_done  output  1  one-cycle pulse at end of a run.
o_ring_idx  output  $clog2(NumRings) (min 1)  index of the ring currently being swept.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all o_real_tuning_dist=0.0; o_locked=0; o_busy=0; o_done=0; o_ring_idx=0; peak=0.0; argmax=0; step and settle counters=0.
- States: IDLE, SWEEP, VERIFY, NEXT, DONE.
- IDLE:
  - When i_start=1 → SWEEP with ring k=0, step s=0.
  - Clear o_locked entirely.
  - Set tuning[0]=0.0, peak=-inf (sentinel), argmax=0.
- SWEEP, one step:
  - tuning[k] holds step s value.
  - Settle counter runs SettleCycles cycles, then one sample cycle, so each step takes SettleCycles+1 cycles.
  - On the sample cycle: if current[k] > peak (strict), set peak=current[k] and argmax=s. On ties the lowest step wins.
  - If s<SweepSteps-1: s++ and tuning[k] is updated to the new step value on the next cycle edge.
  - Otherwise → VERIFY with tuning[k]=argmax*TuningFullScale/(SweepSteps-1).
- VERIFY:
  - Settle SettleCycles cycles, then sample.
  - Set locked[k]=1 iff peak >= MinPeak and sample >= LockRatio*peak.
  - tuning[k] stays at argmax value whether or not lock is declared.
  - → NEXT.
- NEXT, one cycle:
  - If k<NumRings-1: k++, s=0, peak reset, tuning[k+1]=0.0 → SWEEP.
  - Otherwise → DONE.
- DONE, one cycle: o_done=1, then → IDLE.
- Cycle counts:
  - Per ring: (SweepSteps+1)*(SettleCycles+1)+1 cycles.
  - Full run: NumRings times that, plus 1 for DONE.
- Rings not currently being swept hold their last tuning value. Rings ≥k still hold their previous-run values until their own sweep starts.
- i_start while busy is ignored, with no queuing.
- o_ring_idx=k during SWEEP, VERIFY and NEXT; 0 in IDLE and DONE.
- i_real_pd_current must be stable by the sample cycle. Only the sampled ring's input is read.
- Reset mid-run: the run is abandoned, all outputs return to reset values, and the next i_start begins from ring 0.

Test Plan:
1. NumRings=2, SweepSteps=11, Settle=2, Full=10.0. Ring0 model is a Lorentzian peaked at tuning 4.0 (peak 1.0); ring1 peaks at 7.0. → tuning={4.0,7.0}, o_locked=2'b11, o_done pulses exactly 2*(12*3+1)+1=75 cycles after the start edge.
2. Ring0 current is constant 0.0. → peak < MinPeak, o_locked[0]=0, tuning[0]=0.0 (argmax 0); ring1 is unaffected.
3. Equal maxima 0.5 at steps 2 and 7. → tuning=2.0. Then the model drifts so the verify sample is 0.4 (<0.45) → locked[0]=0.
4. Pulse i_start again at cycle 10 of a run. → ignored: run length unchanged, single o_done. A new i_start after DONE clears o_locked and reruns.
5. Assert i_rst_n=0 asynchronously mid-SWEEP of ring1. → all outputs reset immediately with no clock needed. A subsequent start gives o_ring_idx=0.
6. SettleCycles=0, SweepSteps=2. → each step is 1 cycle, tuning toggles 0.0 then 10.0, and the per-ring run is 3*1+1=4 cycles.
